// File: rtl/popcount256_pipe_pkg.sv
// Shared constants and helpers for the 256-bit population counter.
// Slice width, slice count width and result-width helper.
package popcount_pkg;

   localparam int POPCNT_WIDTH       = 256;
   localparam int POPCNT_SLICE_W     = 16;
   localparam int POPCNT_SLICE_CNT_W = 5;
   localparam int NUM_SLICES         = POPCNT_WIDTH / POPCNT_SLICE_W;

   function automatic int count_w(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/popcount256_pipe_if.sv
// Valid-qualified vector in / count out bundle for popcount256_pipe.
// master drives vectors, slave is the counter.
interface popcount256_pipe_if
   import popcount_pkg::*;
#(
   parameter int WIDTH   = POPCNT_WIDTH,
   parameter int COUNT_W = count_w(WIDTH)
) ();

   logic               in_valid;
   logic [WIDTH-1:0]   data;
   logic               out_valid;
   logic [COUNT_W-1:0] count;

   modport master (
      output in_valid,
      output data,
      input  out_valid,
      input  count
   );

   modport slave (
      input  in_valid,
      input  data,
      output out_valid,
      output count
   );

endinterface

// File: rtl/popcount256_pipe_popcount16.sv
// Combinational 16-bit population count: four nibble tables
// followed by a two-level add.
module popcount16
   import popcount_pkg::*;
(
   input  logic [POPCNT_SLICE_W-1:0]     data,
   output logic [POPCNT_SLICE_CNT_W-1:0] count
);

   function automatic logic [2:0] cnt4(input logic [3:0] n);
      logic [2:0] r;
      r = 3'd0;
      case (n)
         4'h0: r = 3'd0;
         4'h1: r = 3'd1;
         4'h2: r = 3'd1;
         4'h3: r = 3'd2;
         4'h4: r = 3'd1;
         4'h5: r = 3'd2;
         4'h6: r = 3'd2;
         4'h7: r = 3'd3;
         4'h8: r = 3'd1;
         4'h9: r = 3'd2;
         4'ha: r = 3'd2;
         4'hb: r = 3'd3;
         4'hc: r = 3'd2;
         4'hd: r = 3'd3;
         4'he: r = 3'd3;
         4'hf: r = 3'd4;
         default: r = 3'd0;
      endcase
      return r;
   endfunction

   logic [2:0] n0, n1, n2, n3;
   logic [3:0] lo, hi;

   assign n0 = cnt4(data[3:0]);
   assign n1 = cnt4(data[7:4]);
   assign n2 = cnt4(data[11:8]);
   assign n3 = cnt4(data[15:12]);

   assign lo    = {1'b0, n0} + {1'b0, n1};
   assign hi    = {1'b0, n2} + {1'b0, n3};
   assign count = {1'b0, lo} + {1'b0, hi};

endmodule

// File: rtl/popcount256_pipe.sv
// Streaming popcount of a WIDTH-bit vector. POPCOUNT_PIPE_EN adds a
// register after the 4-operand tree level (latency 2 instead of 1).
module popcount256_pipe
   import popcount_pkg::*;
#(
   parameter int WIDTH   = POPCNT_WIDTH,
   parameter int COUNT_W = count_w(WIDTH)
) (
   input logic               clk,
   input logic               rst_n,
   popcount256_pipe_if.slave bus
);

   localparam int NSL   = WIDTH / POPCNT_SLICE_W;
   localparam int LVLS  = $clog2(NSL);
   localparam int NL    = 1 << LVLS;
   localparam int SUM_W = POPCNT_SLICE_CNT_W + LVLS;

   // Every tree level lives in one flat vector; level l holds
   // NL>>l nodes of (SLICE_CNT_W + l) bits each.
   function automatic int lvl_base(input int l);
      int b;
      b = 0;
      for (int k = 0; k < l; k++)
         b += (NL >> k) * (POPCNT_SLICE_CNT_W + k);
      return b;
   endfunction

   localparam int TREE_W = lvl_base(LVLS + 1);
   localparam int ROOT_O = lvl_base(LVLS);

   logic [TREE_W-1:0]  tree;
   logic               stage_valid;
   logic               out_valid_q;
   logic [COUNT_W-1:0] count_q;

   for (genvar i = 0; i < NL; i++) begin : g_leaf
      localparam int O = i * POPCNT_SLICE_CNT_W;
      if (i < NSL) begin : g_pc
         popcount16 u_pc (
            .data  (bus.data[i*POPCNT_SLICE_W +: POPCNT_SLICE_W]),
            .count (tree[O +: POPCNT_SLICE_CNT_W])
         );
      end else begin : g_pad
         assign tree[O +: POPCNT_SLICE_CNT_W] = '0;
      end
   end

`ifdef POPCOUNT_PIPE_EN
   localparam int PART_W = POPCNT_SLICE_CNT_W + LVLS - 2;
   localparam int PART_O = lvl_base(LVLS - 2);

   logic [3:0][PART_W-1:0] part;
   logic                   mid_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mid_valid <= 1'b0;
         part      <= '0;
      end else begin
         mid_valid <= bus.in_valid;
         if (bus.in_valid)
            part <= tree[PART_O +: 4*PART_W];
      end
   end

   assign stage_valid = mid_valid;
`else
   assign stage_valid = bus.in_valid;
`endif

   for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
      localparam int W = POPCNT_SLICE_CNT_W + l;
      for (genvar j = 0; j < (NL >> l); j++) begin : g_node
         localparam int O = lvl_base(l) + j * W;
         localparam int A = lvl_base(l - 1) + 2 * j * (W - 1);
         localparam int B = A + W - 1;
`ifdef POPCOUNT_PIPE_EN
         if (l == LVLS - 1) begin : g_reg
            assign tree[O +: W] = {1'b0, part[2*j]}
                                + {1'b0, part[2*j+1]};
         end else begin : g_comb
            assign tree[O +: W] = {1'b0, tree[A +: W-1]}
                                + {1'b0, tree[B +: W-1]};
         end
`else
         assign tree[O +: W] = {1'b0, tree[A +: W-1]}
                             + {1'b0, tree[B +: W-1]};
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         out_valid_q <= stage_valid;
         if (stage_valid)
            count_q <= tree[ROOT_O +: SUM_W];
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_popcount256_pipe.sv
// Directed and random checks for popcount256_pipe in either build.
// Expected counts are hand-computed or from a bit-loop model.
module tb_popcount256_pipe;
   import popcount_pkg::*;

`ifdef POPCOUNT_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   popcount256_pipe_if bus ();

   popcount256_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int ref_pop(input logic [255:0] d);
      int n;
      n = 0;
      for (int i = 0; i < 256; i++)
         if (d[i]) n++;
      return n;
   endfunction

   task automatic test_reset();
      logic [255:0] d;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b exp 0", bus.out_valid);
      end
      checks++;
      if (bus.count !== 9'd0) begin
         errors++;
         $display("FAIL reset_count got %0d exp 0", bus.count);
      end
      rst_n = 1'b1;
      d = (256'd1 << 165) - 256'd1;
      bus.in_valid = 1'b1;
      bus.data = d;
      repeat (LAT + 1) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.count !== 9'h0a5) begin
         errors++;
         $display("FAIL pre_async got v=%b c=%0h exp v=1 c=a5",
                  bus.out_valid, bus.count);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.count !== 9'd0) begin
         errors++;
         $display("FAIL async_clear got v=%b c=%0h exp v=0 c=0",
                  bus.out_valid, bus.count);
      end
      bus.in_valid = 1'b0;
      bus.data = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_extremes();
      logic [255:0] vec [3];
      logic [8:0]   want [3];
      vec[0] = '0;          want[0] = 9'd0;
      vec[1] = '1;          want[1] = 9'h100;
      vec[2] = '1;          want[2] = 9'd255;
      vec[2][255] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.data = vec[k];
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.data = '0;
         repeat (LAT - 1) @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.count !== want[k]) begin
            errors++;
            $display("FAIL extreme%0d got v=%b c=%0d exp v=1 c=%0d",
                     k, bus.out_valid, bus.count, want[k]);
         end
      end
   endtask

   task automatic test_patterns();
      logic [255:0] vec [4];
      logic [8:0]   want [4];
      vec[0] = {64{4'h5}};            want[0] = 9'd128;
      vec[1] = 256'd1;                want[1] = 9'd1;
      vec[2] = 256'd1 << 255;         want[2] = 9'd1;
      vec[3] = 256'hffff << 112;      want[3] = 9'd16;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.data = vec[k];
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.data = '0;
         repeat (LAT - 1) @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.count !== want[k]) begin
            errors++;
            $display("FAIL pattern%0d got v=%b c=%0d exp v=1 c=%0d",
                     k, bus.out_valid, bus.count, want[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] vec [8];
      logic [8:0]   want [8];
      vec[0] = '0;            want[0] = 9'd0;
      vec[1] = 256'd1;        want[1] = 9'd1;
      vec[2] = 256'd3;        want[2] = 9'd2;
      vec[3] = 256'd7;        want[3] = 9'd3;
      vec[4] = 256'hff;       want[4] = 9'd8;
      vec[5] = '1;            want[5] = 9'd256;
      vec[6] = {64{4'h5}};    want[6] = 9'd128;
      vec[7] = 256'd1 << 128; want[7] = 9'd1;
      for (int c = 0; c <= 8 + LAT; c++) begin
         @(negedge clk);
         if (c >= LAT && c < 8 + LAT) begin
            checks++;
            if (bus.out_valid !== 1'b1 ||
                bus.count !== want[c-LAT]) begin
               errors++;
               $display("FAIL stream%0d got v=%b c=%0d exp v=1 c=%0d",
                        c - LAT, bus.out_valid, bus.count, want[c-LAT]);
            end
         end
         if (c == 8 + LAT) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL stream_end got v=%b exp 0", bus.out_valid);
            end
         end
         bus.in_valid = (c < 8);
         bus.data = (c < 8) ? vec[c] : '0;
      end
   endtask

   task automatic test_gaps();
      int         n [8];
      logic [8:0] hold;
      n = '{10, 0, 200, 0, 37, 0, 99, 0};
      hold = '0;
      for (int c = 0; c < 8 + LAT; c++) begin
         @(negedge clk);
         if (c >= LAT) begin
            if (c[0] == LAT[0])
               hold = 9'(n[c-LAT]);
            checks++;
            if (bus.out_valid !== (c[0] == LAT[0]) ||
                bus.count !== hold) begin
               errors++;
               $display("FAIL gap%0d got v=%b c=%0d exp v=%b c=%0d",
                        c - LAT, bus.out_valid, bus.count,
                        (c[0] == LAT[0]), hold);
            end
         end
         if (c < 8) begin
            bus.in_valid = ~c[0];
            bus.data = c[0] ? '1 : (256'd1 << n[c]) - 256'd1;
         end else begin
            bus.in_valid = 1'b0;
            bus.data = '0;
         end
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data = '1;
      @(negedge clk);
      bus.data = {64{4'h5}};
      #2 rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.data = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < LAT + 2; c++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.count !== 9'd0) begin
            errors++;
            $display("FAIL mid_rst%0d got v=%b c=%0d exp v=0 c=0",
                     c, bus.out_valid, bus.count);
         end
      end
   endtask

   task automatic test_random();
      localparam int N = 1000;
      logic [8:0]   want [N];
      logic [255:0] d;
      for (int c = 0; c < N + LAT; c++) begin
         @(negedge clk);
         if (c >= LAT) begin
            checks++;
            if (bus.out_valid !== 1'b1 ||
                bus.count !== want[c-LAT]) begin
               errors++;
               $display("FAIL rand%0d got v=%b c=%0d exp v=1 c=%0d",
                        c - LAT, bus.out_valid, bus.count, want[c-LAT]);
            end
         end
         if (c < N) begin
            for (int w = 0; w < 8; w++) begin
               case (c % 4)
                  0: d[w*32 +: 32] = $urandom & $urandom & $urandom;
                  1: d[w*32 +: 32] = $urandom | $urandom | $urandom;
                  default: d[w*32 +: 32] = $urandom;
               endcase
            end
            want[c] = 9'(ref_pop(d));
            bus.in_valid = 1'b1;
            bus.data = d;
         end else begin
            bus.in_valid = 1'b0;
            bus.data = '0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_extremes();
      test_patterns();
      test_back_to_back();
      test_gaps();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
